// File: rtl/rca_config_loader.sv
// Unpacks the RCA configuration command stream into single-entry write strobes
// for the config register file. Grid bursts are unpacked four selects per data word.
module rca_config_loader #(
  parameter int NUM_RCAS           = 4,
  parameter int NUM_READ_PORTS     = 2,
  parameter int NUM_WRITE_PORTS    = 2,
  parameter int NUM_GRID_MUXES     = 64,
  parameter int GRID_MUX_INPUTS    = 8,
  parameter int GRID_NUM_ROWS      = 4,
  parameter int IO_UNIT_MUX_INPUTS = 8
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  cfg_valid,
  output logic                                  cfg_ready,
  input  logic [31:0]                           cfg_data,
  output logic                                  cfg_active,
  output logic                                  cfg_err,
  input  logic                                  cfg_err_clr,
  output logic [$clog2(NUM_RCAS)-1:0]           rca_sel,
  output logic                                  cpu_fb_reg_addr_wr_en,
  output logic                                  cpu_nfb_reg_addr_wr_en,
  output logic [$clog2(NUM_READ_PORTS)-1:0]     cpu_port_sel,
  output logic                                  cpu_src_dest_port,
  output logic [4:0]                            cpu_reg_addr,
  output logic                                  grid_mux_wr_en,
  output logic [$clog2(NUM_GRID_MUXES)-1:0]     grid_mux_addr,
  output logic [$clog2(GRID_MUX_INPUTS)-1:0]    new_grid_mux_sel,
  output logic                                  io_mux_wr_en,
  output logic [$clog2(GRID_NUM_ROWS)-1:0]      io_mux_addr,
  output logic [$clog2(IO_UNIT_MUX_INPUTS)-1:0] new_io_mux_sel,
  output logic                                  rca_result_mux_wr_en,
  output logic [$clog2(NUM_WRITE_PORTS)-1:0]    rca_result_mux_addr,
  output logic [$clog2(GRID_NUM_ROWS)-1:0]      new_rca_result_mux_sel,
  output logic                                  rca_io_inp_map_wr_en,
  output logic [GRID_NUM_ROWS-1:0]              new_rca_io_inp_map
);
  localparam int RCA_W = $clog2(NUM_RCAS);
  localparam int PS_W  = $clog2(NUM_READ_PORTS);
  localparam int GA_W  = $clog2(NUM_GRID_MUXES);
  localparam int GS_W  = $clog2(GRID_MUX_INPUTS);
  localparam int IA_W  = $clog2(GRID_NUM_ROWS);
  localparam int IS_W  = $clog2(IO_UNIT_MUX_INPUTS);
  localparam int RA_W  = $clog2(NUM_WRITE_PORTS);
  localparam int RS_W  = $clog2(GRID_NUM_ROWS);

  typedef enum logic [1:0] {IDLE, GRID_DATA, GRID_UNPACK} state_t;

  typedef struct packed {
    logic [RCA_W-1:0]         rca_sel;
    logic                     fb_en;
    logic                     nfb_en;
    logic [PS_W-1:0]          port;
    logic                     sd;
    logic [4:0]               reg_addr;
    logic                     grid_en;
    logic [GA_W-1:0]          grid_addr;
    logic [GS_W-1:0]          grid_sel;
    logic                     io_en;
    logic [IA_W-1:0]          io_addr;
    logic [IS_W-1:0]          io_sel;
    logic                     res_en;
    logic [RA_W-1:0]          res_addr;
    logic [RS_W-1:0]          res_sel;
    logic                     map_en;
    logic [GRID_NUM_ROWS-1:0] map;
  } wr_t;

  state_t      state_q, state_d;
  wr_t         wr_q, wr_d;
  logic [15:0] rem_q, rem_d;
  logic [12:0] gaddr_q, gaddr_d;
  logic        ovf_q, ovf_d;
  logic [31:0] word_q, word_d;
  logic [1:0]  bidx_q, bidx_d, cur_idx;
  logic        ready_q, ready_d, active_q, active_d, err_q, err_d, err_set;
  logic        acc, emit, rca_ok;
  logic [GS_W-1:0] sel_v;
  logic [2:0]  op;
  logic [4:0]  rca;
  logic [3:0]  idx;

  assign op  = cfg_data[31:29];
  assign rca = cfg_data[28:24];
  assign idx = cfg_data[23:20];
  assign acc = cfg_valid & ready_q;
  assign rca_ok = 32'(rca) < NUM_RCAS;

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    wr_d.fb_en = 1'b0; wr_d.nfb_en = 1'b0; wr_d.grid_en = 1'b0;
    wr_d.io_en = 1'b0; wr_d.res_en = 1'b0; wr_d.map_en  = 1'b0;
    rem_d   = rem_q;
    gaddr_d = gaddr_q;
    ovf_d   = ovf_q;
    word_d  = word_q;
    bidx_d  = bidx_q;
    cur_idx = bidx_q;
    err_set = 1'b0;
    emit    = 1'b0;
    sel_v   = '0;
    case (state_q)
      IDLE: if (acc) begin
        case (op)
          3'd1: if (rca_ok && 32'(idx) < NUM_READ_PORTS) begin
            wr_d.fb_en = 1'b1; wr_d.sd = 1'b0;
            wr_d.port = idx[PS_W-1:0]; wr_d.reg_addr = cfg_data[4:0];
            wr_d.rca_sel = rca[RCA_W-1:0];
          end else err_set = 1'b1;
          3'd2, 3'd3: if (rca_ok && 32'(idx) < NUM_WRITE_PORTS) begin
            wr_d.fb_en = (op == 3'd2); wr_d.nfb_en = (op == 3'd3); wr_d.sd = 1'b1;
            wr_d.port = idx[PS_W-1:0]; wr_d.reg_addr = cfg_data[4:0];
            wr_d.rca_sel = rca[RCA_W-1:0];
          end else err_set = 1'b1;
          3'd4: if (rca_ok && 32'(idx) < GRID_NUM_ROWS) begin
            wr_d.io_en = 1'b1; wr_d.io_addr = idx[IA_W-1:0];
            wr_d.io_sel = cfg_data[IS_W-1:0]; wr_d.rca_sel = rca[RCA_W-1:0];
          end else err_set = 1'b1;
          3'd5: if (rca_ok && 32'(idx) < NUM_WRITE_PORTS) begin
            wr_d.res_en = 1'b1; wr_d.res_addr = idx[RA_W-1:0];
            wr_d.res_sel = cfg_data[RS_W-1:0]; wr_d.rca_sel = rca[RCA_W-1:0];
          end else err_set = 1'b1;
          3'd6: if (rca_ok) begin
            wr_d.map_en = 1'b1; wr_d.map = cfg_data[GRID_NUM_ROWS-1:0];
            wr_d.rca_sel = rca[RCA_W-1:0];
          end else err_set = 1'b1;
          3'd7: if (cfg_data[15:0] != 16'd0) begin
            rem_d = cfg_data[15:0]; gaddr_d = cfg_data[28:16];
            ovf_d = 1'b0; state_d = GRID_DATA;
          end
          default: ;
        endcase
      end
      GRID_DATA: if (acc) begin
        emit = 1'b1; word_d = cfg_data; sel_v = cfg_data[GS_W-1:0]; cur_idx = 2'd0;
      end
      GRID_UNPACK: begin
        emit = 1'b1; sel_v = word_q[{bidx_q, 3'b000} +: GS_W];
      end
      default: state_d = IDLE;
    endcase
    if (emit) begin
      // The address stalls once past the last mux so it can never wrap back into range
      if (ovf_q || 32'(gaddr_q) >= NUM_GRID_MUXES) begin
        ovf_d = 1'b1; err_set = 1'b1;
      end else begin
        wr_d.grid_en = 1'b1; wr_d.grid_addr = gaddr_q[GA_W-1:0];
        wr_d.grid_sel = sel_v; gaddr_d = gaddr_q + 13'd1;
      end
      rem_d  = rem_q - 16'd1;
      bidx_d = cur_idx + 2'd1;
      if (rem_q == 16'd1)      state_d = IDLE;
      else if (cur_idx == 2'd3) state_d = GRID_DATA;
      else                      state_d = GRID_UNPACK;
    end
    err_d    = (err_q & ~cfg_err_clr) | err_set;
    ready_d  = (state_d != GRID_UNPACK);
    active_d = (state_d != IDLE) | wr_d.fb_en | wr_d.nfb_en | wr_d.grid_en |
               wr_d.io_en | wr_d.res_en | wr_d.map_en;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      wr_q     <= '0;
      rem_q    <= '0;
      gaddr_q  <= '0;
      ovf_q    <= 1'b0;
      word_q   <= '0;
      bidx_q   <= '0;
      ready_q  <= 1'b1;
      active_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_q     <= wr_d;
      rem_q    <= rem_d;
      gaddr_q  <= gaddr_d;
      ovf_q    <= ovf_d;
      word_q   <= word_d;
      bidx_q   <= bidx_d;
      ready_q  <= ready_d;
      active_q <= active_d;
      err_q    <= err_d;
    end
  end

  assign cfg_ready              = ready_q;
  assign cfg_active             = active_q;
  assign cfg_err                = err_q;
  assign rca_sel                = wr_q.rca_sel;
  assign cpu_fb_reg_addr_wr_en  = wr_q.fb_en;
  assign cpu_nfb_reg_addr_wr_en = wr_q.nfb_en;
  assign cpu_port_sel           = wr_q.port;
  assign cpu_src_dest_port      = wr_q.sd;
  assign cpu_reg_addr           = wr_q.reg_addr;
  assign grid_mux_wr_en         = wr_q.grid_en;
  assign grid_mux_addr          = wr_q.grid_addr;
  assign new_grid_mux_sel       = wr_q.grid_sel;
  assign io_mux_wr_en           = wr_q.io_en;
  assign io_mux_addr            = wr_q.io_addr;
  assign new_io_mux_sel         = wr_q.io_sel;
  assign rca_result_mux_wr_en   = wr_q.res_en;
  assign rca_result_mux_addr    = wr_q.res_addr;
  assign new_rca_result_mux_sel = wr_q.res_sel;
  assign rca_io_inp_map_wr_en   = wr_q.map_en;
  assign new_rca_io_inp_map     = wr_q.map;
endmodule
